exec_alu_unit: RTL and testbench

Parametrised execute-stage ALU for the mini CPU. It decodes the ALU control class together with funct3/funct7, computes the result, and presents it through a valid/ready output register. Covered operations: RV32I arithmetic, logic and branch compare, plus optional M-extension multiply and an iterative divide. It replaces the purely combinational op decode feeding the ALU and adds pipelining, back-pressure, multi-cycle divide and flush.

---
 rtl/exec_alu_unit.sv | 184 ++++++++++++++++++
 tb/tb_exec_alu_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_alu_unit.sv
// exec_alu_unit: execute-stage ALU with op decode, M-extension, iterative divide and valid/ready output register
module exec_alu_unit #(
    parameter int XLEN = 32,
    parameter bit HAS_M = 1'b1,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_ctrl_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            itype,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            illegal,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic {IDLE, DIV} state_t;
    state_t state_q, state_d;
    logic out_valid_q, out_valid_d, branch_taken_q, branch_taken_d, illegal_q, illegal_d;
    logic [XLEN-1:0] result_q, result_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d, is_rem_q, is_rem_d;
    logic accept, div_c, brt_c, ill_c, a_sgn, b_sgn, d_sgn, dz, ovf, m_sel;
    logic [XLEN-1:0] res_c, a_mag, b_mag, fin;
    logic [3:0] op4;
    logic [SHW-1:0] shamt;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN:0] rem_sh, diff;

    assign accept = in_valid && in_ready;
    assign shamt = op_b[SHW-1:0];
    assign op4 = {(itype && funct3 != 3'b101) ? 1'b0 : funct7[5], funct3};
    assign m_sel = alu_ctrl_op == 2'b01 && !itype && funct7 == 7'b0000001;
    assign d_sgn = !funct3[0];
    assign a_sgn = op_a[XLEN-1] && (funct3[2] ? d_sgn : funct3[1:0] != 2'b11);
    assign b_sgn = op_b[XLEN-1] && (funct3[2] ? d_sgn : !funct3[1]);
    assign a_ext = {{XLEN{a_sgn}}, op_a};
    assign b_ext = {{XLEN{b_sgn}}, op_b};
    assign prod = a_ext * b_ext;
    assign a_mag = a_sgn ? -op_a : op_a;
    assign b_mag = b_sgn ? -op_b : op_b;
    assign dz = op_b == '0;
    assign ovf = d_sgn && op_a == MIN_NEG && op_b == '1;
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff = rem_sh - {1'b0, dvs_q};
    assign fin = is_rem_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);

    // Decode the request and compute every single-cycle result; divides that need iteration raise div_c
    always_comb begin
        res_c = '0;
        brt_c = 1'b0;
        ill_c = 1'b0;
        div_c = 1'b0;
        case (alu_ctrl_op)
            2'b00: res_c = op_a + op_b;
            2'b01:
                if (m_sel) begin
                    if (!HAS_M) ill_c = 1'b1;
                    else if (!funct3[2]) res_c = funct3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    else if (dz) res_c = funct3[1] ? op_a : '1;
                    else if (ovf) res_c = funct3[1] ? '0 : op_a;
                    else div_c = 1'b1;
                end else
                    case (op4)
                        4'd0: res_c = op_a + op_b;
                        4'd8: res_c = op_a - op_b;
                        4'd1: res_c = op_a << shamt;
                        4'd2: res_c = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                        4'd3: res_c = {{(XLEN-1){1'b0}}, op_a < op_b};
                        4'd4: res_c = op_a ^ op_b;
                        4'd5: res_c = op_a >> shamt;
                        4'd13: res_c = $signed(op_a) >>> shamt;
                        4'd6: res_c = op_a | op_b;
                        4'd7: res_c = op_a & op_b;
                        default: ill_c = 1'b1;
                    endcase
            2'b10: begin
                ill_c = funct3[2:1] == 2'b01;
                brt_c = !ill_c && (funct3[0] ^ (funct3[2] ? (funct3[1] ? op_a < op_b : $signed(op_a) < $signed(op_b)) : op_a == op_b));
                res_c = {{(XLEN-1){1'b0}}, brt_c};
            end
            default: ill_c = 1'b1;
        endcase
    end

    // Output register and restoring-divide datapath next values
    always_comb begin
        out_valid_d = out_valid_q && !out_ready && !flush;
        result_d = result_q;
        branch_taken_d = branch_taken_q;
        illegal_d = illegal_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        is_rem_d = is_rem_q;
        if (accept && !div_c) begin
            out_valid_d = 1'b1;
            result_d = res_c;
            branch_taken_d = brt_c;
            illegal_d = ill_c;
        end
        if (accept && div_c) begin
            quo_d = a_mag;
            rem_d = '0;
            dvs_d = b_mag;
            cnt_d = CW'(XLEN);
            qneg_d = a_sgn ^ b_sgn;
            rneg_d = a_sgn;
            is_rem_d = funct3[1];
        end
        if (state_q == DIV && !flush) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
                quo_d = {quo_q[XLEN-2:0], !diff[XLEN]};
                rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            end else begin
                out_valid_d = 1'b1;
                result_d = fin;
                branch_taken_d = 1'b0;
                illegal_d = 1'b0;
            end
        end
    end

    // Next state: enter DIV on an accepted iterative divide, leave when the count is exhausted or on flush
    always_comb begin
        state_d = flush ? IDLE : state_q == IDLE ? ((accept && div_c) ? DIV : IDLE) : (cnt_q == '0 ? IDLE : DIV);
    end

    // Handshake and status outputs
    always_comb begin
        in_ready = state_q == IDLE && (!out_valid_q || out_ready) && !flush;
        busy = state_q == DIV;
    end

    assign out_valid = out_valid_q;
    assign result = result_q;
    assign branch_taken = branch_taken_q;
    assign illegal = illegal_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_valid_q <= 1'b0;
            result_q <= '0;
            branch_taken_q <= 1'b0;
            illegal_q <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_valid_q <= out_valid_d;
            result_q <= result_d;
            branch_taken_q <= branch_taken_d;
            illegal_q <= illegal_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            is_rem_q <= is_rem_d;
        end
    end
endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit: directed checks of ALU ops, branch compares, divide timing/specials, back-pressure and flush
module tb_exec_alu_unit;
    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready, itype, branch_taken, illegal, busy;
    logic [1:0] alu_ctrl_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] op_a, op_b, result;
    int tests = 0;
    int fails = 0;
    int n;
    logic bad;

    always #5 clk = ~clk;

    exec_alu_unit #(.XLEN(32), .HAS_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl_op(alu_ctrl_op), .funct3(funct3), .funct7(funct7), .itype(itype),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .branch_taken(branch_taken), .illegal(illegal), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [2:0] f3, input logic [6:0] f7, input logic it,
                         input logic [31:0] a, input logic [31:0] b);
        alu_ctrl_op = c;
        funct3 = f3;
        funct7 = f7;
        itype = it;
        op_a = a;
        op_b = b;
    endtask

    task automatic issue(input string tag, input logic [1:0] c, input logic [2:0] f3, input logic [6:0] f7,
                         input logic it, input logic [31:0] a, input logic [31:0] b);
        drive(c, f3, f7, it, a, b);
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int cycles, output logic err);
        drive(2'b01, f3, 7'b0000001, 1'b0, a, b);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cycles = 0;
        err = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (!busy || in_ready) err = 1'b1;
            step();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(2'b00, 3'b000, 7'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 32'h0);
        check("rst_busy", busy, 0);
        check("rst_illegal", illegal, 0);
        check("rst_branch", branch_taken, 0);
        check("rst_in_ready", in_ready, 1);

        issue("sub", 2'b01, 3'b000, 7'b0100000, 1'b0, 32'd5, 32'd7);
        check("sub_result", result, 32'hFFFFFFFE);
        issue("srai", 2'b01, 3'b101, 7'b0100000, 1'b1, 32'h80000000, 32'd4);
        check("srai_result", result, 32'hF8000000);
        issue("srli", 2'b01, 3'b101, 7'b0000000, 1'b1, 32'h80000000, 32'd4);
        check("srli_result", result, 32'h08000000);
        issue("addi_f7", 2'b01, 3'b000, 7'b0100000, 1'b1, 32'd5, 32'd7);
        check("addi_f7_result", result, 32'd12);
        issue("slt", 2'b01, 3'b010, 7'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
        check("slt_result", result, 32'd1);
        issue("sltu", 2'b01, 3'b011, 7'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
        check("sltu_result", result, 32'd0);
        issue("xor", 2'b01, 3'b100, 7'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00);
        check("xor_result", result, 32'h0FF00FF0);
        issue("sll", 2'b01, 3'b001, 7'b0, 1'b0, 32'h1, 32'h23);
        check("sll_result", result, 32'h8);
        issue("ld_add", 2'b00, 3'b010, 7'b0, 1'b1, 32'h1000, 32'hFFFFFFFC);
        check("ld_add_result", result, 32'h00000FFC);
        issue("bad_op", 2'b01, 3'b001, 7'b0100000, 1'b0, 32'd3, 32'd4);
        check("bad_op_illegal", illegal, 1);
        check("bad_op_result", result, 32'h0);

        issue("blt", 2'b10, 3'b100, 7'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
        check("blt_taken", branch_taken, 1);
        check("blt_result", result, 32'd1);
        issue("bgeu", 2'b10, 3'b111, 7'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
        check("bgeu_taken", branch_taken, 1);
        issue("bne", 2'b10, 3'b001, 7'b0, 1'b0, 32'd9, 32'd9);
        check("bne_taken", branch_taken, 0);
        check("bne_result", result, 32'd0);
        issue("br010", 2'b10, 3'b010, 7'b0, 1'b0, 32'd1, 32'd1);
        check("br010_illegal", illegal, 1);
        check("br010_result", result, 32'h0);
        check("br010_taken", branch_taken, 0);
        issue("cls11", 2'b11, 3'b000, 7'b0, 1'b0, 32'd1, 32'd1);
        check("cls11_illegal", illegal, 1);

        run_div(3'b100, 32'hFFFFFFF9, 32'd2, n, bad);
        check("div_latency", n, 33);
        check("div_busy_hold", bad, 0);
        check("div_result", result, 32'hFFFFFFFD);
        check("div_illegal", illegal, 0);
        check("div_busy_end", busy, 0);
        run_div(3'b110, 32'hFFFFFFF9, 32'd2, n, bad);
        check("rem_latency", n, 33);
        check("rem_busy_hold", bad, 0);
        check("rem_result", result, 32'hFFFFFFFF);
        run_div(3'b101, 32'd100, 32'd7, n, bad);
        check("divu_latency", n, 33);
        check("divu_result", result, 32'd14);

        issue("divu0", 2'b01, 3'b101, 7'b0000001, 1'b0, 32'd5, 32'd0);
        check("divu0_result", result, 32'hFFFFFFFF);
        check("divu0_busy", busy, 0);
        issue("remu0", 2'b01, 3'b111, 7'b0000001, 1'b0, 32'd5, 32'd0);
        check("remu0_result", result, 32'd5);
        issue("rem_ovf", 2'b01, 3'b110, 7'b0000001, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        check("rem_ovf_result", result, 32'h0);
        issue("div_ovf", 2'b01, 3'b100, 7'b0000001, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_result", result, 32'h80000000);

        drive(2'b00, 3'b000, 7'b0, 1'b0, 32'd1, 32'd2);
        in_valid = 1'b1;
        step();
        check("bp_first", result, 32'd3);
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'b0, 1'b0, 32'd10, 32'd20);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        step();
        step();
        check("bp_hold_result", result, 32'd3);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", in_ready, 1);
        step();
        check("bp_second", result, 32'd30);
        drive(2'b00, 3'b000, 7'b0, 1'b0, 32'd100, 32'd200);
        step();
        check("bp_third", result, 32'd300);
        check("bp_third_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid, 0);

        drive(2'b01, 3'b101, 7'b0000001, 1'b0, 32'd1000, 32'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        check("fl_busy_before", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("fl_busy_after", busy, 0);
        check("fl_in_ready", in_ready, 1);
        bad = 1'b0;
        repeat (40) begin
            if (out_valid) bad = 1'b1;
            step();
        end
        check("fl_no_valid", bad, 0);
        issue("mulhu", 2'b01, 3'b011, 7'b0000001, 1'b0, 32'h00010000, 32'h00010000);
        check("mulhu_result", result, 32'd1);
        issue("mul", 2'b01, 3'b000, 7'b0000001, 1'b0, 32'h00010000, 32'h00010003);
        check("mul_result", result, 32'h00030000);
        issue("mulhsu", 2'b01, 3'b010, 7'b0000001, 1'b0, 32'hFFFFFFFF, 32'd2);
        check("mulhsu_result", result, 32'hFFFFFFFF);
        issue("mulh", 2'b01, 3'b001, 7'b0000001, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mulh_result", result, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
